// File: rtl/rpn_pkg.sv
// rpn_pkg -- definitions shared by the RPN calculator's push and pop paths.
//   * default stack entry / stack pointer widths
//   * pop-side FSM state encoding
//   * seven-segment glyphs (active-low, bit order g f e d c b a)
package rpn_pkg;

    localparam int RPN_DATA_W = 8;
    localparam int RPN_ADDR_W = 8;

    typedef enum logic [2:0] {
        POP_IDLE  = 3'd0,
        POP_RD_A  = 3'd1,
        POP_CAP_A = 3'd2,
        POP_CAP_B = 3'd3,
        POP_DONE  = 3'd4,
        POP_ERR   = 3'd5
    } pop_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_U     = 7'h41;

endpackage

// File: rtl/reg_load_enable.sv
// reg_load_enable -- W-bit holding register with load enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears q
//   load  : when high, q takes d on the rising edge
//   d     : data in
//   q     : held value
module reg_load_enable #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rpn_stack_reader.sv
// rpn_stack_reader -- pop-side controller for the RPN operand stack.
// Reads one or two entries from the top of the stack RAM, presents them as
// operands and returns the decremented stack pointer for the top level.
//   CLOCK_50  : system clock
//   reset_n   : asynchronous active-low reset
//   sp_in     : current stack pointer (entry count; top entry at sp_in-1)
//   pop_req   : start a pop (sampled only in IDLE)
//   pop_two   : with pop_req, 1 = pop two entries, 0 = pop one
//   mem_q     : stack RAM read data (synchronous read, 1-cycle latency)
//   rd_addr   : stack RAM read address (muxed onto the RAM while busy)
//   busy      : high in every non-IDLE state
//   operand_a : top-of-stack value
//   operand_b : next value (meaningful after a two-pop only)
//   valid     : one-cycle pulse when operands are final
//   sp_out    : new stack pointer
//   sp_load   : one-cycle pulse with valid; top level loads sp_out
//   underflow : one-cycle pulse on a rejected pop
//   state_dbg : current FSM state
//
// Handshake: pop_req is a level request taken only in IDLE; there is no
// ready output, busy high means any request is dropped (not queued). Results
// are announced by the single-cycle valid/sp_load pulse or underflow pulse.
module rpn_stack_reader
    import rpn_pkg::*;
#(
    parameter int DATA_W = RPN_DATA_W,
    parameter int ADDR_W = RPN_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic              pop_req,
    input  logic              pop_two,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic              valid,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_load,
    output logic              underflow,
    output pop_state_t        state_dbg
);

    pop_state_t        state, state_next;
    logic [ADDR_W-1:0] sp_r;
    logic              two_r;
    logic              reject;

    // Underflow is decided from the live inputs on the accept cycle, so the
    // decrements below can never wrap.
    assign reject = pop_two ? (sp_in < ADDR_W'(2)) : (sp_in == '0);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= POP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            POP_IDLE:  if (pop_req) state_next = reject ? POP_ERR : POP_RD_A;
            POP_RD_A:  state_next = POP_CAP_A;
            POP_CAP_A: state_next = two_r ? POP_CAP_B : POP_DONE;
            POP_CAP_B: state_next = POP_DONE;
            POP_DONE:  state_next = POP_IDLE;
            POP_ERR:   state_next = POP_IDLE;
            default:   state_next = POP_IDLE;
        endcase
    end

    // rd_addr is registered one cycle ahead of the state that owns it: it
    // already holds sp-1 during RD_A and sp-2 during CAP_A, and otherwise
    // keeps its last value.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sp_r    <= '0;
            two_r   <= 1'b0;
            rd_addr <= '0;
            sp_out  <= '0;
        end else begin
            case (state)
                POP_IDLE: begin
                    if (pop_req) begin
                        sp_r  <= sp_in;
                        two_r <= pop_two;
                        if (!reject) rd_addr <= sp_in - ADDR_W'(1);
                    end
                end
                POP_RD_A: begin
                    if (two_r) rd_addr <= sp_r - ADDR_W'(2);
                end
                POP_CAP_A: begin
                    if (!two_r) sp_out <= sp_r - ADDR_W'(1);
                end
                POP_CAP_B: begin
                    sp_out <= sp_r - ADDR_W'(2);
                end
                default: ;
            endcase
        end
    end

    reg_load_enable #(.W(DATA_W)) u_operand_a (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .load  (state == POP_CAP_A),
        .d     (mem_q),
        .q     (operand_a)
    );

    reg_load_enable #(.W(DATA_W)) u_operand_b (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .load  (state == POP_CAP_B),
        .d     (mem_q),
        .q     (operand_b)
    );

    assign busy      = (state != POP_IDLE);
    assign valid     = (state == POP_DONE);
    assign sp_load   = (state == POP_DONE);
    assign underflow = (state == POP_ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_rpn_stack_reader.sv
module tb_rpn_stack_reader;
    import rpn_pkg::*;

    logic       CLOCK_50;
    logic       reset_n;
    logic [7:0] sp_in;
    logic       pop_req;
    logic       pop_two;
    logic [7:0] mem_q;
    logic [7:0] rd_addr;
    logic       busy;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       valid;
    logic [7:0] sp_out;
    logic       sp_load;
    logic       underflow;
    pop_state_t state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int load_cnt = 0;
    int uf_cnt = 0;

    logic [7:0] ram [256];
    logic [7:0] exp_q [$];

    // clock / reset block
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    rpn_stack_reader dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .sp_in     (sp_in),
        .pop_req   (pop_req),
        .pop_two   (pop_two),
        .mem_q     (mem_q),
        .rd_addr   (rd_addr),
        .busy      (busy),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .valid     (valid),
        .sp_out    (sp_out),
        .sp_load   (sp_load),
        .underflow (underflow),
        .state_dbg (state_dbg)
    );

    // stack RAM model: synchronous read, one cycle latency
    always @(posedge CLOCK_50) mem_q <= ram[rd_addr];

    // pulse counters (outputs sampled before the edge updates them)
    always @(posedge CLOCK_50) begin
        if (valid)     valid_cnt++;
        if (sp_load)   load_cnt++;
        if (underflow) uf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    // drive a request for one cycle (cycle 0); returns at the cycle-1 negedge
    task automatic start_pop(input logic [7:0] sp, input logic two);
        sp_in   = sp;
        pop_two = two;
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
    endtask

    initial begin
        int vc, lc, uc, cyc;
        logic [7:0] exp_sp;
        bit uf_seen;

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[0] = 8'd11;
        ram[1] = 8'd22;
        ram[2] = 8'd33;
        reset_n = 1'b0;
        sp_in   = '0;
        pop_req = 1'b0;
        pop_two = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_sp_load", sp_load, 0);
        check("rst_underflow", underflow, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_op_a", operand_a, 0);
        check("rst_op_b", operand_b, 0);
        check("rst_sp_out", sp_out, 0);
        reset_n = 1'b1;
        tick();

        // single pop, sp=3
        start_pop(8'd3, 1'b0);
        check("sp1_c1_busy", busy, 1);
        check("sp1_c1_addr", rd_addr, 2);
        check("sp1_c1_valid", valid, 0);
        tick();
        check("sp1_c2_valid", valid, 0);
        check("sp1_c2_addr", rd_addr, 2);
        tick();
        check("sp1_c3_valid", valid, 1);
        check("sp1_c3_load", sp_load, 1);
        check("sp1_c3_op_a", operand_a, 33);
        check("sp1_c3_op_b", operand_b, 0);
        check("sp1_c3_sp_out", sp_out, 2);
        check("sp1_c3_busy", busy, 1);
        tick();
        check("sp1_c4_valid", valid, 0);
        check("sp1_c4_busy", busy, 0);

        // two-pop, sp=3
        start_pop(8'd3, 1'b1);
        check("sp2_c1_addr", rd_addr, 2);
        tick();
        check("sp2_c2_addr", rd_addr, 1);
        tick();
        check("sp2_c3_valid", valid, 0);
        check("sp2_c3_busy", busy, 1);
        tick();
        check("sp2_c4_valid", valid, 1);
        check("sp2_c4_load", sp_load, 1);
        check("sp2_c4_op_a", operand_a, 33);
        check("sp2_c4_op_b", operand_b, 22);
        check("sp2_c4_sp_out", sp_out, 1);
        tick();
        check("sp2_c5_busy", busy, 0);

        // underflow: sp=1 two-pop, then sp=0 single pop
        for (int k = 0; k < 2; k++) begin
            vc = valid_cnt;
            lc = load_cnt;
            uc = uf_cnt;
            start_pop(k == 0 ? 8'd1 : 8'd0, k == 0);
            check("uf_c1_underflow", underflow, 1);
            check("uf_c1_busy", busy, 1);
            check("uf_c1_valid", valid, 0);
            check("uf_c1_load", sp_load, 0);
            check("uf_c1_addr", rd_addr, 1);
            tick();
            check("uf_c2_busy", busy, 0);
            check("uf_c2_underflow", underflow, 0);
            check("uf_op_a_kept", operand_a, 33);
            check("uf_op_b_kept", operand_b, 22);
            check("uf_sp_out_kept", sp_out, 1);
            check("uf_valid_pulses", valid_cnt - vc, 0);
            check("uf_load_pulses", load_cnt - lc, 0);
            check("uf_uf_pulses", uf_cnt - uc, 1);
        end

        // busy ignore: extra requests in cycles 1..3 of a two-pop
        vc = valid_cnt;
        uc = uf_cnt;
        start_pop(8'd3, 1'b1);
        sp_in   = 8'd0;
        pop_two = 1'b0;
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        tick();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        check("bi_c4_valid", valid, 1);
        check("bi_c4_sp_out", sp_out, 1);
        tick();
        tick();
        tick();
        check("bi_valid_pulses", valid_cnt - vc, 1);
        check("bi_uf_pulses", uf_cnt - uc, 0);
        check("bi_idle", busy, 0);

        // reset mid-pop: reset in cycle 2 of a two-pop
        lc = load_cnt;
        start_pop(8'd3, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", valid, 0);
        check("mr_load", sp_load, 0);
        check("mr_rd_addr", rd_addr, 0);
        check("mr_op_a", operand_a, 0);
        check("mr_op_b", operand_b, 0);
        check("mr_sp_out", sp_out, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("mr_no_load", load_cnt - lc, 0);

        // fresh two-pop after reset, sp=2
        start_pop(8'd2, 1'b1);
        tick();
        tick();
        tick();
        check("fr_valid", valid, 1);
        check("fr_op_a", operand_a, 22);
        check("fr_op_b", operand_b, 11);
        check("fr_sp_out", sp_out, 0);
        tick();

        // back-to-back single pops with pop_req held, sp fed back from sp_out
        exp_q = '{8'd33, 8'd22, 8'd11};
        exp_sp = 8'd2;
        uf_seen = 1'b0;
        sp_in   = 8'd3;
        pop_two = 1'b0;
        pop_req = 1'b1;
        for (cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (valid) begin
                check("b2b_valid_cycle", cyc, 3 + 4 * (2 - exp_sp));
                if (exp_q.size() == 0) begin
                    check("b2b_extra_valid", 1, 0);
                end else begin
                    check("b2b_op_a", operand_a, exp_q.pop_front());
                end
                check("b2b_sp_out", sp_out, exp_sp);
                exp_sp = exp_sp - 8'd1;
            end
            if (sp_load) sp_in = sp_out;
            if (underflow) begin
                check("b2b_uf_cycle", cyc, 13);
                uf_seen = 1'b1;
                pop_req = 1'b0;
                break;
            end
        end
        pop_req = 1'b0;
        check("b2b_uf_seen", uf_seen, 1);
        check("b2b_all_popped", exp_q.size(), 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
